chip7458_top: RTL and testbench



---
 rtl/chip7458_and_or_cell.sv | 12 +
 rtl/chip7458_top.sv | 53 +++++
 tb/tb_chip7458_top.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/chip7458_and_or_cell.sv
// rtl/chip7458_and_or_cell.sv - one AND-OR section: y = &ga | &gb
module and_or_cell #(
    parameter int W = 2
) (
    input  logic [W-1:0] ga,
    input  logic [W-1:0] gb,
    output logic         y
);

    assign y = (&ga) | (&gb);

endmodule

// File: rtl/chip7458_top.sv
// rtl/chip7458_top.sv - 7458 dual AND-OR package; REG_OUT_EN adds a 1-cycle output register
module chip7458_top (
    input  logic clk,
    input  logic reset,
    input  logic p1a,
    input  logic p1b,
    input  logic p1c,
    input  logic p1d,
    input  logic p1e,
    input  logic p1f,
    output logic p1y,
    input  logic p2a,
    input  logic p2b,
    input  logic p2c,
    input  logic p2d,
    output logic p2y
);

    logic sec1_y;
    logic sec2_y;

    and_or_cell #(.W(3)) u_sec1 (
        .ga ({p1c, p1b, p1a}),
        .gb ({p1f, p1e, p1d}),
        .y  (sec1_y)
    );

    and_or_cell #(.W(2)) u_sec2 (
        .ga ({p2b, p2a}),
        .gb ({p2d, p2c}),
        .y  (sec2_y)
    );

`ifdef REG_OUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            p1y <= 1'b0;
            p2y <= 1'b0;
        end else begin
            p1y <= sec1_y;
            p2y <= sec2_y;
        end
    end
`else
    // clk and reset stay on the pinout but are not used by the combinational build
    logic unused_ctrl;
    assign unused_ctrl = clk ^ reset;

    assign p1y = sec1_y;
    assign p2y = sec2_y;
`endif

endmodule

// File: tb/tb_chip7458_top.sv
// tb/tb_chip7458_top.sv - directed and random checks of chip7458_top, both builds
module tb_chip7458_top;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic p1a = 1'b0, p1b = 1'b0, p1c = 1'b0, p1d = 1'b0, p1e = 1'b0, p1f = 1'b0;
    logic p2a = 1'b0, p2b = 1'b0, p2c = 1'b0, p2d = 1'b0;
    logic p1y, p2y;

    int n_checks = 0;
    int n_fail = 0;

    chip7458_top dut (
        .clk   (clk),
        .reset (reset),
        .p1a   (p1a),
        .p1b   (p1b),
        .p1c   (p1c),
        .p1d   (p1d),
        .p1e   (p1e),
        .p1f   (p1f),
        .p1y   (p1y),
        .p2a   (p2a),
        .p2b   (p2b),
        .p2c   (p2c),
        .p2d   (p2d),
        .p2y   (p2y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic actual, input logic expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", tag, actual, expected);
        end
    endtask

    task automatic settle();
`ifdef REG_OUT_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    task automatic set1(input logic [5:0] v);
        {p1a, p1b, p1c, p1d, p1e, p1f} = v;
    endtask

    task automatic set2(input logic [3:0] v);
        {p2a, p2b, p2c, p2d} = v;
    endtask

    function automatic logic sec2_expected(input logic [3:0] code);
        case (code)
            4'b1100, 4'b0011, 4'b1101, 4'b1110,
            4'b0111, 4'b1011, 4'b1111: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

    initial begin
        logic [5:0] r1;
        logic [3:0] r2;
        logic       e1;
        logic       e2;

`ifdef REG_OUT_EN
        repeat (2) @(posedge clk);
        #1;
        check("reset_p1y", p1y, 1'b0);
        check("reset_p2y", p2y, 1'b0);
`endif
        reset = 1'b0;

        set1(6'b000000); set2(4'b0000);
        settle();
        check("zero_p1y", p1y, 1'b0);
        check("zero_p2y", p2y, 1'b0);

        set1(6'b111000);
        settle();
        check("grpA_p1y", p1y, 1'b1);
        check("grpA_p2y", p2y, 1'b0);
        p1b = 1'b0;
        settle();
        check("grpA_clr_p1y", p1y, 1'b0);

        set1(6'b000111); set2(4'b0011);
        settle();
        check("grpB_p1y", p1y, 1'b1);
        check("grpB_p2y", p2y, 1'b1);
        p2d = 1'b0;
        settle();
        check("p2d_clr_p2y", p2y, 1'b0);
        check("p2d_clr_p1y", p1y, 1'b1);

        // section 1 held at 0 so any cross-section leak shows on p1y
        set1(6'b000000);
        for (int c = 0; c < 16; c++) begin
            set2(c[3:0]);
            settle();
            check($sformatf("sweep2_%b", c[3:0]), p2y, sec2_expected(c[3:0]));
            check($sformatf("sweep2_iso_%b", c[3:0]), p1y, 1'b0);
        end

        set2(4'b0000);
        for (int c = 0; c < 64; c++) begin
            r1 = c[5:0];
            set1(r1);
            settle();
            check($sformatf("sweep1_%b", r1), p1y, (r1[5] & r1[4] & r1[3]) | (r1[2] & r1[1] & r1[0]));
            check($sformatf("sweep1_iso_%b", r1), p2y, 1'b0);
        end

        for (int i = 0; i < 400; i++) begin
`ifdef REG_OUT_EN
            @(negedge clk);
`else
            if (i % 2 == 0) @(posedge clk);
            else            @(negedge clk);
`endif
            r1 = 6'($urandom);
            r2 = 4'($urandom);
            set1(r1);
            set2(r2);
            e1 = (r1[5] & r1[4] & r1[3]) | (r1[2] & r1[1] & r1[0]);
            e2 = (r2[3] & r2[2]) | (r2[1] & r2[0]);
            settle();
            check($sformatf("rand%0d_p1y", i), p1y, e1);
            check($sformatf("rand%0d_p2y", i), p2y, e2);
        end

        set1(6'b111111); set2(4'b1111);
        reset = 1'b1;
`ifdef REG_OUT_EN
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_p1y", p1y, 1'b0);
        check("rst_hold_p2y", p2y, 1'b0);
        reset = 1'b0;
        #1;
        check("rst_rel_pre_p1y", p1y, 1'b0);
        check("rst_rel_pre_p2y", p2y, 1'b0);
        @(posedge clk);
        #1;
        check("rst_rel_p1y", p1y, 1'b1);
        check("rst_rel_p2y", p2y, 1'b1);
`else
        @(posedge clk);
        #1;
        check("rst_noeffect_p1y", p1y, 1'b1);
        check("rst_noeffect_p2y", p2y, 1'b1);
        reset = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
